// File: rtl/uart_tx_wrapper_pkg.sv
// Shared definitions for the UART transmitter peripheral: register word
// offsets, STATUS/CTRL bit positions and serializer state encoding.
// Optional parity support is selected with the UART_TX_PARITY_EN macro.
package uart_tx_wrapper_pkg;

  localparam logic [1:0] ADDR_TXDATA  = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_BAUDDIV = 2'd2;
  localparam logic [1:0] ADDR_CTRL    = 2'd3;

  localparam int ST_BUSY    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_FULL    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;
  localparam int ST_CNT_W   = 7;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_CLR     = 1;
  localparam int CTRL_OVF_CLR = 2;
  localparam int CTRL_PAR_ODD = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_wrapper_tx_fifo.sv
// Synchronous transmit FIFO with push, pop and clear. A push while full is
// accepted only when a pop happens on the same edge.
module tx_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    clear,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy tracking; clear discards all queued entries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_wrapper.sv
// Memory-mapped UART transmitter: register window, read mux, FIFO and
// baud-timed serializer. Define UART_TX_PARITY_EN to add a parity bit
// (CTRL[3] selects odd parity).
module uart_tx_wrapper
  import uart_tx_wrapper_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        tx,
  output logic        irq
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             wr_txdata, wr_baud, wr_ctrl;
  logic [DIV_W-1:0] baud_div;
  logic             enable;
  logic             parity_odd;
  logic             overflow;
  logic             fifo_clear;
  logic [7:0]       fifo_rdata;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  tx_state_e        state_q, state_d;
  logic             pop;
  logic [DIV_W-1:0] baud_cnt;
  logic             bit_end;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_q;
  logic             par_q;
  logic             busy;

  assign wr_txdata  = we && (address == ADDR_TXDATA);
  assign wr_baud    = we && (address == ADDR_BAUDDIV);
  assign wr_ctrl    = we && (address == ADDR_CTRL);
  assign fifo_clear = wr_ctrl && data_in[CTRL_CLR];
  assign bit_end    = (baud_cnt == '0);
  assign busy       = (state_q != S_IDLE);
  assign irq        = fifo_empty && !busy;

  tx_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata),
    .pop   (pop),
    .clear (fifo_clear),
    .wdata (data_in[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Configuration registers and the sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_div <= '0;
      enable   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_baud) baud_div <= data_in[DIV_W-1:0];
      if (wr_ctrl) begin
        enable <= data_in[CTRL_EN];
        if (data_in[CTRL_OVF_CLR]) overflow <= 1'b0;
      end
      if (wr_txdata && fifo_full && !pop) overflow <= 1'b1;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity sense, writable and readable through CTRL.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       parity_odd <= 1'b0;
    else if (wr_ctrl) parity_odd <= data_in[CTRL_PAR_ODD];
  end
`else
  assign parity_odd = 1'b0;
`endif

  // Serializer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and pop decision; every bit ends when baud_cnt hits 0.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && !fifo_empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA: begin
        if (bit_end && (bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP:   if (bit_end) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Bit timer and data bit index; divisor is resampled only at bit boundaries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
    end else if (pop) begin
      baud_cnt <= baud_div;
      bit_idx  <= 3'd0;
    end else if (busy) begin
      if (bit_end) begin
        baud_cnt <= baud_div;
        if (state_q == S_DATA) bit_idx <= bit_idx + 3'd1;
      end else begin
        baud_cnt <= baud_cnt - 1'b1;
      end
    end
  end

  // Frame data: byte captured on pop, shifted out LSB first.
  always_ff @(posedge clk) begin
    if (pop) begin
      shift_q <= fifo_rdata;
      par_q   <= (^fifo_rdata) ^ parity_odd;
    end else if ((state_q == S_DATA) && bit_end) begin
      shift_q <= {1'b0, shift_q[7:1]};
    end
  end

  // Serial line level from the current state; idle and stop are high.
  always_comb begin
    tx = 1'b1;
    case (state_q)
      S_START:  tx = 1'b0;
      S_DATA:   tx = shift_q[0];
      S_PARITY: tx = par_q;
      default:  tx = 1'b1;
    endcase
  end

  // Register read mux; unused bits read as zero.
  always_comb begin
    data_out = '0;
    case (address)
      ADDR_STATUS: begin
        data_out[ST_BUSY]  = busy;
        data_out[ST_EMPTY] = fifo_empty;
        data_out[ST_FULL]  = fifo_full;
        data_out[ST_OVF]   = overflow;
        data_out[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(fifo_count);
      end
      ADDR_BAUDDIV: data_out[DIV_W-1:0] = baud_div;
      ADDR_CTRL: begin
        data_out[CTRL_EN]      = enable;
        data_out[CTRL_PAR_ODD] = parity_odd;
      end
      default: data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_wrapper.sv
// Self-checking bench for uart_tx_wrapper: register vector table followed by
// serial frame sequences. Parity cases follow UART_TX_PARITY_EN.
module tb_uart_tx_wrapper;
  import uart_tx_wrapper_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [1:0]  address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        tx;
  logic        irq;

  int n_vec = 0;
  int n_bad = 0;

  uart_tx_wrapper #(.FIFO_DEPTH(8), .DIV_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .address  (address),
    .data_in  (data_in),
    .data_out (data_out),
    .tx       (tx),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wen;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One-cycle register write; returns at the negedge after the commit edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; address = a; data_in = d;
    @(negedge clk);
    we = 1'b0; address = ADDR_STATUS;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1 d = data_out;
  endtask

  // Check one full frame sample by sample, first sample at the next negedge.
  // clr_at >= 0 issues a CTRL enable+fifo_clear write during that sample.
  task automatic check_frame(input logic [7:0] b, input int div, input int nbits,
                             input logic par, input int clr_at);
    logic [10:0] bits;
    logic        seen;
    logic        busy_seen;
    int          k;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
    if (nbits == 11) bits[9] = par;
    k = 0;
    busy_seen = 1'b1;
    for (int bi = 0; bi < nbits; bi++) begin
      seen = bits[bi];
      for (int c = 0; c <= div; c++) begin
        @(negedge clk);
        if (k == clr_at) begin
          we = 1'b1; address = ADDR_CTRL; data_in = 32'h3;
        end else begin
          we = 1'b0; address = ADDR_STATUS;
        end
        #1;
        if (tx !== bits[bi]) seen = tx;
        if ((address == ADDR_STATUS) && (data_out[ST_BUSY] !== 1'b1)) busy_seen = 1'b0;
        k++;
      end
      chk($sformatf("frame_%02h_bit%0d", b, bi), {31'd0, seen}, {31'd0, bits[bi]});
    end
    we = 1'b0; address = ADDR_STATUS;
    chk($sformatf("frame_%02h_busy", b), {31'd0, busy_seen}, 32'd1);
  endtask

  // Push one byte with the serializer enabled and check the one idle cycle.
  task automatic send(input logic [7:0] b, input int div, input int nbits, input logic par);
    @(negedge clk);
    we = 1'b1; address = ADDR_TXDATA; data_in = {24'd0, b};
    @(negedge clk);
    we = 1'b0; address = ADDR_STATUS;
    #1 chk($sformatf("pre_start_%02h", b), {31'd0, tx}, 32'd1);
    check_frame(b, div, nbits, par, -1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        stuck;
    reset = 1'b0; we = 1'b0; address = ADDR_STATUS; data_in = '0;
    repeat (3) @(negedge clk);
    #1 chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_irq", {31'd0, irq}, 32'd1);
    @(negedge clk);
    reset = 1'b1;

    tbl.push_back('{"rst_status",  1'b0, ADDR_TXDATA,  32'h0,        ADDR_STATUS,  32'h2});
    tbl.push_back('{"rst_baud",    1'b0, ADDR_TXDATA,  32'h0,        ADDR_BAUDDIV, 32'h0});
    tbl.push_back('{"rst_ctrl",    1'b0, ADDR_TXDATA,  32'h0,        ADDR_CTRL,    32'h0});
    tbl.push_back('{"baud_rw",     1'b1, ADDR_BAUDDIV, 32'hDEADBEEF, ADDR_BAUDDIV, 32'hBEEF});
    tbl.push_back('{"status_ro",   1'b1, ADDR_STATUS,  32'hFFFFFFFF, ADDR_STATUS,  32'h2});
    tbl.push_back('{"ctrl_strobe", 1'b1, ADDR_CTRL,    32'h6,        ADDR_CTRL,    32'h0});
    tbl.push_back('{"push1",       1'b1, ADDR_TXDATA,  32'h11,       ADDR_STATUS,  32'h10});
    tbl.push_back('{"txdata_rd0",  1'b0, ADDR_TXDATA,  32'h0,        ADDR_TXDATA,  32'h0});
    tbl.push_back('{"push2",       1'b1, ADDR_TXDATA,  32'h22,       ADDR_STATUS,  32'h20});
    tbl.push_back('{"push3",       1'b1, ADDR_TXDATA,  32'h33,       ADDR_STATUS,  32'h30});
    tbl.push_back('{"push4",       1'b1, ADDR_TXDATA,  32'h44,       ADDR_STATUS,  32'h40});
    tbl.push_back('{"push5",       1'b1, ADDR_TXDATA,  32'h55,       ADDR_STATUS,  32'h50});
    tbl.push_back('{"push6",       1'b1, ADDR_TXDATA,  32'h66,       ADDR_STATUS,  32'h60});
    tbl.push_back('{"push7",       1'b1, ADDR_TXDATA,  32'h77,       ADDR_STATUS,  32'h70});
    tbl.push_back('{"push8_full",  1'b1, ADDR_TXDATA,  32'h88,       ADDR_STATUS,  32'h84});
    tbl.push_back('{"push9_ovf",   1'b1, ADDR_TXDATA,  32'h99,       ADDR_STATUS,  32'h8C});
    tbl.push_back('{"ovf_clear",   1'b1, ADDR_CTRL,    32'h4,        ADDR_STATUS,  32'h84});
    tbl.push_back('{"fifo_clear",  1'b1, ADDR_CTRL,    32'h2,        ADDR_STATUS,  32'h2});
    tbl.push_back('{"baud_zero",   1'b1, ADDR_BAUDDIV, 32'h0,        ADDR_BAUDDIV, 32'h0});

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wen) wr(tbl[i].waddr, tbl[i].wdata);
      else            @(negedge clk);
      rd(tbl[i].raddr, r);
      chk(tbl[i].name, r, tbl[i].exp);
    end

    // Single byte, four cycles per bit.
    wr(ADDR_BAUDDIV, 32'd3);
    wr(ADDR_CTRL, 32'h1);
    send(8'hA5, 3, 10, 1'b0);
    @(negedge clk);
    rd(ADDR_STATUS, r);
    chk("a5_after_status", r, 32'h2);
    chk("a5_after_tx", {31'd0, tx}, 32'd1);
    chk("a5_after_irq", {31'd0, irq}, 32'd1);

    // Back-to-back frames at one cycle per bit.
    wr(ADDR_CTRL, 32'h0);
    wr(ADDR_BAUDDIV, 32'd0);
    wr(ADDR_TXDATA, 32'h00);
    wr(ADDR_TXDATA, 32'hFF);
    rd(ADDR_STATUS, r);
    chk("b2b_queued", r, 32'h20);
    @(negedge clk);
    we = 1'b1; address = ADDR_CTRL; data_in = 32'h1;
    @(negedge clk);
    we = 1'b0; address = ADDR_STATUS;
    #1 chk("b2b_pre_start", {31'd0, tx}, 32'd1);
    check_frame(8'h00, 0, 10, 1'b0, -1);
    @(negedge clk);
    #1 chk("b2b_gap", {31'd0, tx}, 32'd1);
    check_frame(8'hFF, 0, 10, 1'b0, -1);
    @(negedge clk);
    rd(ADDR_STATUS, r);
    chk("b2b_done", r, 32'h2);

    // fifo_clear during a frame with two bytes still queued.
    wr(ADDR_CTRL, 32'h0);
    wr(ADDR_BAUDDIV, 32'd3);
    wr(ADDR_TXDATA, 32'h3C);
    wr(ADDR_TXDATA, 32'h11);
    wr(ADDR_TXDATA, 32'h22);
    @(negedge clk);
    we = 1'b1; address = ADDR_CTRL; data_in = 32'h1;
    @(negedge clk);
    we = 1'b0; address = ADDR_STATUS;
    #1 chk("clr_pre_start", {31'd0, tx}, 32'd1);
    check_frame(8'h3C, 3, 10, 1'b0, 6);
    stuck = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      #1 if (tx !== 1'b1) stuck = 1'b0;
    end
    chk("clr_no_more_frames", {31'd0, stuck}, 32'd1);
    rd(ADDR_STATUS, r);
    chk("clr_status", r, 32'h2);
    rd(ADDR_CTRL, r);
    chk("clr_ctrl_enable", r, 32'h1);

`ifdef UART_TX_PARITY_EN
    wr(ADDR_BAUDDIV, 32'd1);
    wr(ADDR_CTRL, 32'h1);
    send(8'h07, 1, 11, 1'b1);
    wr(ADDR_CTRL, 32'h9);
    rd(ADDR_CTRL, r);
    chk("par_ctrl_rd", r, 32'h9);
    send(8'h07, 1, 11, 1'b0);
`else
    wr(ADDR_BAUDDIV, 32'd1);
    wr(ADDR_CTRL, 32'h9);
    rd(ADDR_CTRL, r);
    chk("nopar_ctrl_rd", r, 32'h1);
    send(8'h07, 1, 10, 1'b0);
`endif
    @(negedge clk);
    rd(ADDR_STATUS, r);
    chk("par_done", r, 32'h2);

    // Asynchronous reset in the middle of a frame.
    wr(ADDR_BAUDDIV, 32'd3);
    wr(ADDR_CTRL, 32'h1);
    @(negedge clk);
    we = 1'b1; address = ADDR_TXDATA; data_in = 32'h00;
    @(negedge clk);
    we = 1'b0; address = ADDR_STATUS;
    repeat (8) @(negedge clk);
    #1 chk("pre_reset_tx", {31'd0, tx}, 32'd0);
    #1 reset = 1'b0;
    #1 chk("async_reset_tx", {31'd0, tx}, 32'd1);
    chk("async_reset_irq", {31'd0, irq}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    rd(ADDR_STATUS, r);
    chk("post_reset_status", r, 32'h2);
    rd(ADDR_BAUDDIV, r);
    chk("post_reset_baud", r, 32'h0);
    rd(ADDR_CTRL, r);
    chk("post_reset_ctrl", r, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_wrapper.md
# uart_tx_wrapper

Memory-mapped UART transmitter peripheral occupying one address window behind the main address decoder, alongside the factorial and GPIO wrappers. The CPU writes bytes into a small transmit FIFO; a baud-rate-timed serializer drains it onto a single serial line. Status and configuration are readable through the same four-word register window, and read data returns on the shared data-out mux.

## Interface
Parameters:
- FIFO_DEPTH, 8, transmit FIFO entries; power of two, 2..64
- DIV_W, 16, width of baud divisor register

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- we  in  1  write enable for this window (from decoder)
- address  in  2  word select, CPU address bits [3:2]
- data_in  in  32  CPU write data
- data_out  out  32  register read data, combinational from address
- tx  out  1  serial output, idle high
- irq  out  1  high while FIFO empty and serializer idle

## Operation
- Register map (word select): 0 TXDATA (W: push data_in[7:0]; R: 0); 1 STATUS (R only: [0] busy, [1] fifo_empty, [2] fifo_full, [3] overflow sticky, [10:4] fifo_count); 2 BAUDDIV (RW, [DIV_W-1:0], others read 0); 3 CTRL (RW: [0] enable; W-only strobes [1] fifo_clear, [2] overflow_clear, read as 0).
- Writes to STATUS ignored. Unused read bits are 0.
- TXDATA write when FIFO full: byte dropped, overflow set; FIFO unchanged.
- Serializer FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: tx=1; if enable=1 and FIFO non-empty, pop head, load shift register, go START.
- START: tx=0. DATA: 8 bits LSB first, bit index 0..7. STOP: tx=1, one bit.
- Each bit lasts BAUDDIV+1 clk cycles; BAUDDIV=0 gives one cycle per bit.
- BAUDDIV change takes effect at next bit boundary; never mid-bit.
- enable cleared mid-frame: current frame completes; no new pop.
- fifo_clear: empties FIFO same edge; in-flight frame completes.
- busy = FSM not IDLE.
- Simultaneous push and pop on same edge: count unchanged, both succeed; push to a full FIFO with simultaneous pop is accepted (no overflow).
- Simultaneous fifo_clear and TXDATA push in same cycle: impossible (different addresses).

## Timing
- Reset values: tx=1, irq=1, FSM IDLE, FIFO empty, count=0, overflow=0, BAUDDIV=0, enable=0, data_out reflects these.
- Register writes commit at rising clk; readback visible next cycle.
- Pop occurs on the edge leaving IDLE; tx falls to 0 in the following cycle (1 cycle from pop decision to start bit).
- Frame length: 10×(BAUDDIV+1) cycles, 11× with parity.
- Back-to-back: with FIFO non-empty, STOP exits to IDLE then pops next edge; one idle cycle (tx=1) between frames.
- reset asserted mid-frame: tx forced to 1 immediately (asynchronous), all state cleared.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state inserted after DATA; CTRL[3] parity_odd (0 even, 1 odd), readable; parity bit = XOR of data bits XOR parity_odd.
- Undefined: no PARITY state, CTRL[3] reads 0 and ignores writes, frame is 10 bits.

## Structure
- Shared package: register word offsets, STATUS/CTRL bit positions, FSM state encoding.
- One sub-module: tx_fifo (synchronous FIFO, push/pop/clear, full/empty/count); wrapper holds registers, read mux, serializer FSM and baud counter.

## Test plan
- Reset: after reset release, read STATUS -> 0x0000_0002 (empty), tx=1, irq=1.
- Single byte: BAUDDIV=3, enable=1, write 0xA5 -> tx bits 0,1,0,1,0,0,1,0,1,1 each 4 cycles, busy high 40 cycles, irq returns high after.
- Overflow: enable=0, write 9 bytes with FIFO_DEPTH=8 -> STATUS count=8, full=1, overflow=1; write CTRL=0x4 -> overflow=0, count still 8.
- Back-to-back: BAUDDIV=0, queue 0x00,0xFF -> two 10-cycle frames separated by exactly one tx=1 cycle.
- Mid-frame control: during frame of 0x3C write CTRL fifo_clear with 2 bytes queued -> current frame completes, no further frames, count=0.
- Parity (macro on): CTRL=0x1 (even), send 0x07 -> parity bit 1; CTRL=0x9 (odd) -> 0; frame 11 bits.
